qpsk_tx_modulator: RTL and testbench

- QPSK transmit stage directly upstream of the receive demodulator.
- Accepts 2-bit symbols through a valid/ready handshake and buffers them in a small FIFO.
- Synthesises one carrier period per symbol and drives the 9-bit signed channel sample, plus the sin/cos reference the receiver correlates against.
- Symbol mapping, amplitude (100) and timing (32 samples/symbol, one sample every 4 clocks) match the receiver's head threshold (>60 magnitude), 100-scaled first Q sample and sign-to-symbol decoding.

---
 rtl/qpsk_tx_modulator_if.sv | 9 +
 rtl/qpsk_tx_modulator.sv | 194 +++++++++++++++++++
 tb/tb_qpsk_tx_modulator.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qpsk_tx_modulator_if.sv
// rtl/qpsk_tx_modulator_if.sv - symbol handshake interface for the QPSK transmit modulator
interface qpsk_tx_modulator_if;
    logic [1:0] sym_data;
    logic       sym_valid;
    logic       sym_ready;

    modport master (output sym_data, output sym_valid, input sym_ready);
    modport slave  (input sym_data, input sym_valid, output sym_ready);
endinterface

// File: rtl/qpsk_tx_modulator.sv
// rtl/qpsk_tx_modulator.sv - QPSK transmit modulator with symbol FIFO (optional TX_PREAMBLE_EN)
module qpsk_tx_modulator #(
    parameter int SAMPLE_DIV = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    qpsk_tx_modulator_if.slave    sym_if,
    output logic signed [8:0]     mod_out_o,
    output logic signed [8:0]     sin_out_o,
    output logic signed [8:0]     cos_out_o,
    output logic                  tx_busy_o,
    output logic                  sym_start_o
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
`ifdef TX_PREAMBLE_EN
    localparam bit PREAMBLE = 1'b1;
`else
    localparam bit PREAMBLE = 1'b0;
`endif

    typedef enum logic {IDLE, TX} state_t;

    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q;
    logic          push, pop, empty, div_wrap;
    logic [1:0]    head;

    state_t            state_q;
    logic [4:0]        phase_q;
    logic [DW-1:0]     div_q;
    logic [1:0]        cur_sym_q;
    logic signed [8:0] mod_q, sin_q, cos_q;
    logic              busy_q, start_q;

    // Quarter-wave magnitudes of round(100*sin), index 0..8.
    function automatic logic [6:0] quarter(input logic [3:0] i);
        case (i)
            4'd0:    quarter = 7'd0;
            4'd1:    quarter = 7'd20;
            4'd2:    quarter = 7'd38;
            4'd3:    quarter = 7'd56;
            4'd4:    quarter = 7'd71;
            4'd5:    quarter = 7'd83;
            4'd6:    quarter = 7'd92;
            4'd7:    quarter = 7'd98;
            default: quarter = 7'd100;
        endcase
    endfunction

    // Full 32-entry sine built by mirroring within each half and negating the second half.
    function automatic logic signed [8:0] sin_lut(input logic [4:0] k);
        logic [3:0] j;
        logic [3:0] jm;
        logic [6:0] m;
        j  = k[3:0];
        jm = 4'd0 - j;
        m  = (j <= 4'd8) ? quarter(j) : quarter(jm);
        sin_lut = k[4] ? -$signed({2'b00, m}) : $signed({2'b00, m});
    endfunction

    // Ic*sin + Qc*cos; bit0 selects I sign, bit1 inverts Q.
    function automatic logic signed [8:0] mod_sample(input logic [1:0] sym, input logic [4:0] k);
        logic signed [8:0] s, c;
        s = sin_lut(k);
        c = sin_lut(k + 5'd8);
        mod_sample = (sym[0] ? s : -s) + (sym[1] ? -c : c);
    endfunction

    assign empty            = (count_q == '0);
    assign head             = mem_q[rd_q];
    assign push             = sym_if.sym_valid && ready_q;
    assign div_wrap         = (div_q == DIV_MAX);
    assign sym_if.sym_ready = ready_q;

    // Pop decision: symbol load from IDLE (unless a preamble goes first) or at a symbol boundary.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            IDLE:    pop = !empty && !PREAMBLE;
            TX:      pop = div_wrap && (phase_q == 5'd31) && !empty;
            default: pop = 1'b0;
        endcase
    end

    // Next FIFO occupancy.
    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;
    end

    // FIFO storage, written on accepted handshake.
    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wr_q] <= sym_if.sym_data;
    end

    // FIFO pointers, count and registered ready (low while full, regardless of a pop).
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push)
                wr_q <= wr_q + 1'b1;
            if (pop)
                rd_q <= rd_q + 1'b1;
            count_q <= count_d;
            ready_q <= (count_d != FULL_CNT);
        end
    end

    // Symbol sequencer: sample timing, phase stepping and registered carrier outputs.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            div_q     <= '0;
            cur_sym_q <= '0;
            mod_q     <= '0;
            sin_q     <= '0;
            cos_q     <= 9'sd100;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    phase_q <= '0;
                    div_q   <= '0;
                    if (!empty) begin
                        state_q   <= TX;
                        busy_q    <= 1'b1;
                        start_q   <= 1'b1;
                        cur_sym_q <= PREAMBLE ? 2'b01 : head;
                        mod_q     <= mod_sample(PREAMBLE ? 2'b01 : head, 5'd0);
                        sin_q     <= sin_lut(5'd0);
                        cos_q     <= sin_lut(5'd8);
                    end else begin
                        busy_q <= 1'b0;
                        mod_q  <= '0;
                        sin_q  <= '0;
                        cos_q  <= 9'sd100;
                    end
                end
                TX: begin
                    if (!div_wrap) begin
                        div_q <= div_q + 1'b1;
                    end else begin
                        div_q <= '0;
                        if (phase_q != 5'd31) begin
                            phase_q <= phase_q + 5'd1;
                            mod_q   <= mod_sample(cur_sym_q, phase_q + 5'd1);
                            sin_q   <= sin_lut(phase_q + 5'd1);
                            cos_q   <= sin_lut(phase_q + 5'd9);
                        end else if (!empty) begin
                            phase_q   <= '0;
                            cur_sym_q <= head;
                            start_q   <= 1'b1;
                            mod_q     <= mod_sample(head, 5'd0);
                            sin_q     <= sin_lut(5'd0);
                            cos_q     <= sin_lut(5'd8);
                        end else begin
                            state_q <= IDLE;
                            phase_q <= '0;
                            busy_q  <= 1'b0;
                            mod_q   <= '0;
                            sin_q   <= '0;
                            cos_q   <= 9'sd100;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mod_out_o   = mod_q;
    assign sin_out_o   = sin_q;
    assign cos_out_o   = cos_q;
    assign tx_busy_o   = busy_q;
    assign sym_start_o = start_q;
endmodule

// File: tb/tb_qpsk_tx_modulator.sv
// tb/tb_qpsk_tx_modulator.sv - self-checking bench for qpsk_tx_modulator (honours TX_PREAMBLE_EN)
module tb_qpsk_tx_modulator;
    localparam int DIV      = 4;
    localparam int DEPTH    = 4;
    localparam int SYM_CLKS = 32 * DIV;

    logic              clk;
    logic              rst_n;
    logic signed [8:0] mod_out, sin_out, cos_out;
    logic              tx_busy, sym_start;

    qpsk_tx_modulator_if sym_if ();

    qpsk_tx_modulator #(.SAMPLE_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .reset_i     (rst_n),
        .sym_if      (sym_if.slave),
        .mod_out_o   (mod_out),
        .sin_out_o   (sin_out),
        .cos_out_o   (cos_out),
        .tx_busy_o   (tx_busy),
        .sym_start_o (sym_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference trig straight from the carrier definition.
    function automatic int ref_sin(input int k);
        real x;
        x = 100.0 * $sin(2.0 * 3.14159265358979 * k / 32.0);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction
    function automatic int ref_cos(input int k);
        return ref_sin((k + 8) % 32);
    endfunction
    function automatic int ref_mod(input logic [1:0] s, input int k);
        return (s[0] ? 1 : -1) * ref_sin(k) + (s[1] ? -1 : 1) * ref_cos(k);
    endfunction

    // Behavioural model: a queue of symbols and a clock count within the current symbol.
    logic [1:0] mq[$];
    logic [1:0] m_cur = 2'b00;
    int         m_t = 0;
    bit         m_busy = 0, m_start = 0, m_ready = 0;

    always @(posedge clk) begin
        bit         do_push;
        logic [1:0] pdata;
        if (!rst_n) begin
            mq.delete();
            m_busy = 0; m_t = 0; m_start = 0; m_ready = 0;
        end else begin
            do_push = sym_if.sym_valid && m_ready;
            pdata   = sym_if.sym_data;
            m_start = 0;
            if (!m_busy) begin
                if (mq.size() > 0) begin
                    m_busy = 1; m_t = 0; m_start = 1;
`ifdef TX_PREAMBLE_EN
                    m_cur = 2'b01;
`else
                    m_cur = mq.pop_front();
`endif
                end
            end else if (m_t == SYM_CLKS - 1) begin
                if (mq.size() > 0) begin
                    m_cur = mq.pop_front(); m_t = 0; m_start = 1;
                end else begin
                    m_busy = 0;
                end
            end else begin
                m_t++;
            end
            if (do_push) mq.push_back(pdata);
            m_ready = (mq.size() < DEPTH);
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        int k;
        if (chk_en) begin
            k = m_t / DIV;
            check("mod_out", int'(mod_out), m_busy ? ref_mod(m_cur, k) : 0);
            check("sin_out", int'(sin_out), m_busy ? ref_sin(k) : 0);
            check("cos_out", int'(cos_out), m_busy ? ref_cos(k) : 100);
            check("tx_busy", int'(tx_busy), int'(m_busy));
            check("sym_start", int'(sym_start), int'(m_start));
            check("sym_ready", int'(sym_if.sym_ready), int'(m_ready));
        end
    end

    // Cycle counter, accepted-symbol log and decoded-symbol log.
    int         cyc = 0;
    logic [1:0] acc[$];
    logic [1:0] dec[$];
    int         st_cyc[$];
    int         st_val[$];
    int         busy_cnt = 0;
    int         start_cnt = 0;
    bit         pend = 0;
    bit         s1 = 0;
    int         t8 = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst_n && sym_if.sym_valid && sym_if.sym_ready)
            acc.push_back(sym_if.sym_data);
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (tx_busy) busy_cnt++;
            if (sym_start) begin
                start_cnt++;
                st_cyc.push_back(cyc);
                st_val.push_back(int'(mod_out));
                s1   = (mod_out < 0);
                t8   = cyc + 8 * DIV;
                pend = 1;
            end
            if (pend && cyc == t8) begin
                dec.push_back({s1, mod_out > 0});
                pend = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_sym(input logic [1:0] s);
        int g;
        g = 0;
        sym_if.sym_data  = s;
        sym_if.sym_valid = 1'b1;
        while (!sym_if.sym_ready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) check("push_timeout", 0, 1);
        @(negedge clk);
        sym_if.sym_valid = 1'b0;
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        while (!sym_start && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 1000) check("start_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((tx_busy || sym_start) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 5000) check("idle_timeout", 0, 1);
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         c0;
        int         idx;
        int         g;
        bit         saw_full;
        logic [1:0] list[10];

        rst_n            = 1'b0;
        sym_if.sym_valid = 1'b0;
        sym_if.sym_data  = 2'b00;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_mod", int'(mod_out), 0);
        check("rst_cos", int'(cos_out), 100);
        check("rst_sin", int'(sin_out), 0);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_ready", int'(sym_if.sym_ready), 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("ready_after_rst", int'(sym_if.sym_ready), 1);

`ifdef TX_PREAMBLE_EN
        push_sym(2'b10);
        wait_start(lat);
        check("pre_latency", lat, 1);
        check("pre_s0", int'(mod_out), 100);
        tick(SYM_CLKS);
        check("pre_second_start", int'(sym_start), 1);
        check("pre_second_s0", int'(mod_out), -100);
        tick(SYM_CLKS);
        check("pre_idle_busy", int'(tx_busy), 0);
        check("pre_idle_mod", int'(mod_out), 0);
        wait_idle();
`else
        // Single 01 symbol.
        push_sym(2'b01);
        wait_start(lat);
        check("s01_latency", lat, 1);
        check("s01_k0", int'(mod_out), 100);
        tick(DIV - 1);
        check("s01_k0_hold", int'(mod_out), 100);
        tick(1);
        check("s01_k1", int'(mod_out), 118);
        tick(7 * DIV);
        check("s01_k8", int'(mod_out), 100);
        tick(8 * DIV);
        check("s01_k16", int'(mod_out), -100);
        tick(SYM_CLKS - 16 * DIV);
        check("s01_end_busy", int'(tx_busy), 0);
        check("s01_end_mod", int'(mod_out), 0);
        wait_idle();

        // Single 10 symbol.
        push_sym(2'b10);
        wait_start(lat);
        check("s10_k0_raw", int'(mod_out[8:0]), 'h19C);
        check("s10_k0_sin", int'(sin_out), 0);
        check("s10_k0_cos", int'(cos_out), 100);
        tick(4 * DIV);
        check("s10_k4", int'(mod_out), -142);
        check("s10_k4_sin", int'(sin_out), 71);
        check("s10_k4_cos", int'(cos_out), 71);
        tick(4 * DIV);
        check("s10_k8", int'(mod_out), -100);
        check("s10_k8_sin", int'(sin_out), 100);
        check("s10_k8_cos", int'(cos_out), 0);
        wait_idle();

        // Back-to-back 00,11,01,10.
        st_cyc.delete(); st_val.delete(); busy_cnt = 0; start_cnt = 0;
        push_sym(2'b00);
        push_sym(2'b11);
        push_sym(2'b01);
        push_sym(2'b10);
        wait_start(lat);
        wait_idle();
        check("b2b_starts", start_cnt, 4);
        check("b2b_busy_cycles", busy_cnt, 4 * SYM_CLKS);
        if (st_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++)
                check("b2b_interval", st_cyc[i] - st_cyc[i-1], SYM_CLKS);
            check("b2b_s0_a", st_val[0], 100);
            check("b2b_s0_b", st_val[1], -100);
            check("b2b_s0_c", st_val[2], 100);
            check("b2b_s0_d", st_val[3], -100);
        end

        // Continuous valid with the FIFO filling up.
        list = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01, 2'b00, 2'b11, 2'b11, 2'b01};
        acc.delete(); dec.delete();
        saw_full = 0; idx = 0; g = 0;
        sym_if.sym_data  = list[0];
        sym_if.sym_valid = 1'b1;
        while (idx < 10 && g < 5000) begin
            if (sym_if.sym_ready) idx++;
            else saw_full = 1;
            @(negedge clk);
            g++;
            if (idx < 10) sym_if.sym_data = list[idx];
        end
        sym_if.sym_valid = 1'b0;
        check("full_all_pushed", idx, 10);
        check("full_seen", int'(saw_full), 1);
        wait_idle();
        check("sb_acc_count", acc.size(), 10);
        check("sb_dec_count", dec.size(), 10);
        if (dec.size() == 10 && acc.size() == 10)
            for (int i = 0; i < 10; i++) begin
                check("sb_acc_order", int'(acc[i]), int'(list[i]));
                check("sb_dec_sym", int'(dec[i]), int'(list[i]));
            end
`endif

        // Reset at phase 17 with two symbols queued.
        push_sym(2'b00);
        wait_start(lat);
        c0 = cyc;
        push_sym(2'b11);
        push_sym(2'b01);
        while (cyc < c0 + 17 * DIV + 1) @(negedge clk);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_mod", int'(mod_out), 0);
        check("mid_rst_busy", int'(tx_busy), 0);
        check("mid_rst_cos", int'(cos_out), 100);
        rst_n = 1'b1;
        tick(1);
        check("mid_rst_ready", int'(sym_if.sym_ready), 1);
        start_cnt = 0;
        tick(3 * SYM_CLKS);
        check("mid_rst_no_start", start_cnt, 0);
        check("mid_rst_idle", int'(tx_busy), 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
